prog_loader: RTL and testbench

Front-end stage that feeds the `islemci` processor core. It accepts a 16-bit command/data word stream and writes it into the core's instruction and data memories. It then launches the core through its `valid_in`/`valid_out` handshake and streams a selected Dmem window back out. This block replaces bench-side `$readmemb`/`$readmemh` preloading and hierarchical result peeking with a synthesizable load–run–dump path.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_if.sv | 52 +++++
 rtl/run_watchdog.sv | 46 ++++
 rtl/prog_loader.sv | 258 +++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared constants for the islemci program loader: command opcodes, the
// command word field positions and the loader state encoding.
// No ports (package).

package prog_loader_pkg;

  // Command opcodes carried in the top two bits of the CMD word
  localparam logic [1:0] OP_LOAD_IMEM = 2'b00;
  localparam logic [1:0] OP_LOAD_DMEM = 2'b01;
  localparam logic [1:0] OP_RUN       = 2'b10;
  localparam logic [1:0] OP_DUMP      = 2'b11;

  // CMD word layout: opcode in [15:14], base address in the low AW bits
  localparam int CMD_OP_MSB = 15;
  localparam int CMD_OP_LSB = 14;

  // Loader states, kept as plain constants so older tools can read them
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CMD      = 3'd1;
  localparam state_t ST_LEN      = 3'd2;
  localparam state_t ST_LOAD     = 3'd3;
  localparam state_t ST_RUN      = 3'd4;
  localparam state_t ST_DUMP_RD  = 3'd5;
  localparam state_t ST_DUMP_OUT = 3'd6;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
// Bundles every non-clock signal of the program loader: the command/data
// input stream, the Imem/Dmem write ports, the core run handshake, the dump
// output stream and the status flags.
// Modports:
//   master - the loader itself (drives memories, core valid_in, dump stream)
//   slave  - the environment (feeds commands, memories, core, dump sink)

interface prog_loader_if #(
  parameter int AW = 8,
  parameter int DW = 16
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;

  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;

  logic          proc_valid_in;
  logic          proc_valid_out;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  logic          busy;
  logic          err;

  modport master (
    input  in_valid, in_data, dmem_rdata, proc_valid_out, out_ready,
    output in_ready, imem_we, imem_addr, imem_wdata,
           dmem_we, dmem_addr, dmem_wdata, proc_valid_in,
           out_valid, out_data, out_last, busy, err
  );

  modport slave (
    output in_valid, in_data, dmem_rdata, proc_valid_out, out_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata,
           dmem_we, dmem_addr, dmem_wdata, proc_valid_in,
           out_valid, out_data, out_last, busy, err
  );

endinterface

// File: rtl/run_watchdog.sv
// run_watchdog
// Loadable down-counter that bounds how long the core may run.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load_i     - reload the counter with TIMEOUT
//   en_i       - count down one step per cycle while high
//   expired_o  - one-cycle pulse on the last permitted cycle

module run_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reload wins over counting; the counter parks at zero so the expiry
  // pulse cannot repeat until the next reload.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Firing while the count reads 1 makes the run last exactly TIMEOUT cycles
  assign expired_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Load-run-dump front end for the islemci core. Two-word commands (CMD then
// LEN) arrive on the input stream: LOAD_IMEM/LOAD_DMEM write LEN payload words
// from the base address, RUN pulses the core handshake until it reports done
// (or the watchdog trips), DUMP streams a Dmem window back out.
// Optional build macro: PROG_LOADER_CHECKSUM_EN appends a running sum of all
// loaded words as one extra word after every non-empty dump.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - prog_loader_if master: in_*, imem_*, dmem_*, proc_valid_*,
//              out_*, busy, err

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int RUN_TIMEOUT = 4096
) (
  input logic           clk,
  input logic           rst,
  prog_loader_if.master bus
);

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          imemWe_q, imemWe_d;
  logic [AW-1:0] imemAddr_q, imemAddr_d;
  logic [DW-1:0] imemWdata_q, imemWdata_d;
  logic          dmemWe_q, dmemWe_d;
  logic [AW-1:0] dmemAddr_q, dmemAddr_d;
  logic [DW-1:0] dmemWdata_q, dmemWdata_d;
  logic          procValid_q, procValid_d;
  logic          outValid_q, outValid_d;
  logic [DW-1:0] outData_q, outData_d;
  logic          outLast_q, outLast_d;
  logic          inReady_q, inReady_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          inAcc;
  logic          wdLoad;
  logic          wdExpired;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
  logic          sumPhase_q, sumPhase_d;
`endif

  assign inAcc = bus.in_valid && inReady_q;

  run_watchdog #(.TIMEOUT(RUN_TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .load_i    (wdLoad),
    .en_i      (state_q == ST_RUN),
    .expired_o (wdExpired)
  );

  // Main sequencer. Every output is a register, so this block computes the
  // next value of each one; write enables default low to give one-cycle pulses.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    imemWe_d    = 1'b0;
    imemAddr_d  = imemAddr_q;
    imemWdata_d = imemWdata_q;
    dmemWe_d    = 1'b0;
    dmemAddr_d  = dmemAddr_q;
    dmemWdata_d = dmemWdata_q;
    procValid_d = procValid_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outLast_d   = outLast_q;
    err_d       = err_q;
    wdLoad      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    sumPhase_d  = sumPhase_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_CMD;
      ST_CMD: begin
        if (inAcc) begin
          op_d    = bus.in_data[CMD_OP_MSB:CMD_OP_LSB];
          ptr_d   = bus.in_data[AW-1:0];
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (inAcc) begin
          rem_d = bus.in_data;
          if (op_q == OP_RUN) begin
            state_d     = ST_RUN;
            procValid_d = 1'b1;
            wdLoad      = 1'b1;
          end else if (bus.in_data == '0) begin
            state_d = ST_CMD;
          end else if (op_q == OP_DUMP) begin
            // ptr runs one address ahead of dmem_addr during a dump
            state_d    = ST_DUMP_RD;
            dmemAddr_d = ptr_q;
            ptr_d      = ptr_q + AW'(1);
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (inAcc) begin
          if (op_q == OP_LOAD_IMEM) begin
            imemWe_d    = 1'b1;
            imemAddr_d  = ptr_q;
            imemWdata_d = bus.in_data;
          end else begin
            dmemWe_d    = 1'b1;
            dmemAddr_d  = ptr_q;
            dmemWdata_d = bus.in_data;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q + bus.in_data;
`endif
          ptr_d = ptr_q + AW'(1);
          rem_d = rem_q - DW'(1);
          if (rem_q == DW'(1)) begin
            state_d = ST_CMD;
          end
        end
      end
      ST_RUN: begin
        // A completion seen on the same cycle as expiry counts as success
        if (bus.proc_valid_out) begin
          procValid_d = 1'b0;
          state_d     = ST_CMD;
        end else if (wdExpired) begin
          procValid_d = 1'b0;
          err_d       = 1'b1;
          state_d     = ST_CMD;
        end
      end
      ST_DUMP_RD: state_d = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (!outValid_q) begin
          // First DUMP_OUT cycle: read data for dmem_addr is now valid
          outValid_d = 1'b1;
          outData_d  = bus.dmem_rdata;
`ifdef PROG_LOADER_CHECKSUM_EN
          outLast_d  = 1'b0;
`else
          outLast_d  = (rem_q == DW'(1));
`endif
        end else if (bus.out_ready) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (sumPhase_q) begin
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
            sumPhase_d = 1'b0;
            state_d    = ST_CMD;
          end else if (rem_q == DW'(1)) begin
            // Keep out_valid up and swap in the checksum as the final word
            outData_d  = csum_q;
            outLast_d  = 1'b1;
            sumPhase_d = 1'b1;
          end else begin
            outValid_d = 1'b0;
            rem_d      = rem_q - DW'(1);
            dmemAddr_d = ptr_q;
            ptr_d      = ptr_q + AW'(1);
            state_d    = ST_DUMP_RD;
          end
`else
          outValid_d = 1'b0;
          outLast_d  = 1'b0;
          if (rem_q == DW'(1)) begin
            state_d = ST_CMD;
          end else begin
            rem_d      = rem_q - DW'(1);
            dmemAddr_d = ptr_q;
            ptr_d      = ptr_q + AW'(1);
            state_d    = ST_DUMP_RD;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it
  assign inReady_d = (state_d == ST_CMD) || (state_d == ST_LEN) || (state_d == ST_LOAD);
  assign busy_d    = (state_d != ST_IDLE);

  // State and output registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      dmemWe_q    <= 1'b0;
      dmemAddr_q  <= '0;
      dmemWdata_q <= '0;
      procValid_q <= 1'b0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
      inReady_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      sumPhase_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      imemWe_q    <= imemWe_d;
      imemAddr_q  <= imemAddr_d;
      imemWdata_q <= imemWdata_d;
      dmemWe_q    <= dmemWe_d;
      dmemAddr_q  <= dmemAddr_d;
      dmemWdata_q <= dmemWdata_d;
      procValid_q <= procValid_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outLast_q   <= outLast_d;
      inReady_q   <= inReady_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      sumPhase_q  <= sumPhase_d;
`endif
    end
  end

  assign bus.in_ready      = inReady_q;
  assign bus.imem_we       = imemWe_q;
  assign bus.imem_addr     = imemAddr_q;
  assign bus.imem_wdata    = imemWdata_q;
  assign bus.dmem_we       = dmemWe_q;
  assign bus.dmem_addr     = dmemAddr_q;
  assign bus.dmem_wdata    = dmemWdata_q;
  assign bus.proc_valid_in = procValid_q;
  assign bus.out_valid     = outValid_q;
  assign bus.out_data      = outData_q;
  assign bus.out_last      = outLast_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Directed bench for prog_loader: a table of load commands plus hand-written
// run, dump, timeout and mid-load reset sequences. A second instance with a
// short watchdog covers the run timeout.

module tb_prog_loader;

  logic clk;
  logic rst;

  prog_loader_if #(.AW(8), .DW(16)) bus ();
  prog_loader_if #(.AW(8), .DW(16)) busTo ();

  prog_loader #(.AW(8), .DW(16), .RUN_TIMEOUT(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  prog_loader #(.AW(8), .DW(16), .RUN_TIMEOUT(16)) dutTo (
    .clk (clk),
    .rst (rst),
    .bus (busTo)
  );

  typedef struct packed {
    logic [15:0]       cmd;
    logic [15:0]       len;
    logic [3:0][15:0]  data;
    logic              isImem;
    logic [3:0][7:0]   addr;
    logic [2:0]        nWr;
  } loadVec_t;

  typedef struct packed {
    logic        isImem;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  loadVec_t    vecs [3];
  wr_t         wrQ [$];
  logic [15:0] dmem [256];
  logic [15:0] expSum;
  int          nChecks = 0;
  int          nFail   = 0;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dmem model: synchronous read with one cycle of latency
  always @(posedge clk) begin
    if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    bus.dmem_rdata <= dmem[bus.dmem_addr];
  end

  // Record every write pulse the loader issues, one entry per cycle high
  always @(negedge clk) begin
    if (bus.imem_we) wrQ.push_back(wr_t'({1'b1, bus.imem_addr, bus.imem_wdata}));
    if (bus.dmem_we) wrQ.push_back(wr_t'({1'b0, bus.dmem_addr, bus.dmem_wdata}));
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one word on the chosen instance's input stream and wait for accept
  task automatic sendWord(input logic [15:0] w, input bit toTo);
    int   t;
    logic rdy;
    t = 0;
    @(negedge clk);
    if (toTo) begin busTo.in_valid = 1'b1; busTo.in_data = w; end
    else      begin bus.in_valid   = 1'b1; bus.in_data   = w; end
    rdy = toTo ? busTo.in_ready : bus.in_ready;
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
      rdy = toTo ? busTo.in_ready : bus.in_ready;
    end
    if (!rdy) checkOutput("inReadyWait", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    #1;
    if (toTo) busTo.in_valid = 1'b0;
    else      bus.in_valid   = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " imem_we"},       bus.imem_we,       0);
    checkOutput({tag, " imem_addr"},     bus.imem_addr,     0);
    checkOutput({tag, " imem_wdata"},    bus.imem_wdata,    0);
    checkOutput({tag, " dmem_we"},       bus.dmem_we,       0);
    checkOutput({tag, " dmem_addr"},     bus.dmem_addr,     0);
    checkOutput({tag, " dmem_wdata"},    bus.dmem_wdata,    0);
    checkOutput({tag, " proc_valid_in"}, bus.proc_valid_in, 0);
    checkOutput({tag, " out_valid"},     bus.out_valid,     0);
    checkOutput({tag, " out_last"},      bus.out_last,      0);
    checkOutput({tag, " in_ready"},      bus.in_ready,      0);
    checkOutput({tag, " busy"},          bus.busy,          0);
    checkOutput({tag, " err"},           bus.err,           0);
  endtask

  // Run one load vector and compare the captured write pulses with the table
  task automatic applyStimulus(input loadVec_t v, input int idx);
    wrQ.delete();
    sendWord(v.cmd, 1'b0);
    sendWord(v.len, 1'b0);
    for (int k = 0; k < int'(v.len); k++) begin
      sendWord(v.data[k], 1'b0);
      expSum = expSum + v.data[k];
    end
    @(negedge clk);
    if (v.len == 16'd0) checkOutput($sformatf("vec%0d inReadyAfterZeroLen", idx), bus.in_ready, 1);
    repeat (3) @(negedge clk);
    checkOutput($sformatf("vec%0d wrCount", idx), wrQ.size(), 32'(v.nWr));
    for (int k = 0; k < int'(v.nWr) && k < wrQ.size(); k++) begin
      checkOutput($sformatf("vec%0d wr%0d target", idx, k), wrQ[k].isImem, v.isImem);
      checkOutput($sformatf("vec%0d wr%0d addr", idx, k),   wrQ[k].addr,   v.addr[k]);
      checkOutput($sformatf("vec%0d wr%0d data", idx, k),   wrQ[k].data,   v.data[k]);
    end
  endtask

  // Drain nExp dump words, optionally toggling out_ready every cycle.
  // Must be entered on a negedge.
  task automatic collectDump(input logic [5:0][15:0] expW, input int nExp, input bit toggle);
    int          got;
    int          cyc;
    bit          pending;
    logic [15:0] prevData;
    got = 0; cyc = 0; pending = 1'b0; prevData = '0;
    bus.out_ready = toggle ? 1'b0 : 1'b1;
    while (got < nExp && cyc < 100) begin
      if (toggle) bus.out_ready = ~bus.out_ready;
      if (pending) checkOutput($sformatf("dump hold%0d", got), bus.out_data, prevData);
      if (bus.out_valid && bus.out_ready) begin
        checkOutput($sformatf("dump word%0d", got), bus.out_data, expW[got]);
        checkOutput($sformatf("dump last%0d", got), bus.out_last, (got == nExp - 1) ? 1 : 0);
        got++;
        pending = 1'b0;
      end else begin
        pending  = bus.out_valid;
        prevData = bus.out_data;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("dump count", got, nExp);
    checkOutput("dump validDrop", bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  // Hard stop if something hangs outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: got hang, expected finish");
    nFail++;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $fatal(1, "[TB] simulation hung");
  end

  // Main test sequence
  initial begin
    logic [5:0][15:0] expW;
    loadVec_t         post;
    int               hc;
    int               nW;

    vecs[0] = '{cmd: 16'h4025, len: 16'd4,
                data: {16'h0066, 16'h0055, 16'h0050, 16'h0040}, isImem: 1'b0,
                addr: {8'd40, 8'd39, 8'd38, 8'd37}, nWr: 3'd4};
    vecs[1] = '{cmd: 16'h00FE, len: 16'd3,
                data: {16'h0000, 16'h3333, 16'h2222, 16'h1111}, isImem: 1'b1,
                addr: {8'h00, 8'h00, 8'hFF, 8'hFE}, nWr: 3'd3};
    vecs[2] = '{cmd: 16'h0005, len: 16'd0,
                data: '0, isImem: 1'b1, addr: '0, nWr: 3'd0};

    for (int i = 0; i < 256; i++) dmem[i] = '0;
    rst = 1'b1;
    expSum = '0;
    bus.in_valid = 1'b0;   bus.in_data = '0;
    bus.proc_valid_out = 1'b0; bus.out_ready = 1'b0;
    busTo.in_valid = 1'b0; busTo.in_data = '0; busTo.dmem_rdata = '0;
    busTo.proc_valid_out = 1'b0; busTo.out_ready = 1'b0;

    // Reset values, then IDLE for one cycle before CMD
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("cmdAfterIdle in_ready", bus.in_ready, 1);
    checkOutput("cmdAfterIdle busy", bus.busy, 1);

    // Table-driven loads: Dmem window, wrapping Imem load, zero length
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i);

    // Run: core reports done after 100 cycles of valid_in
    sendWord(16'h8000, 1'b0);
    sendWord(16'h0005, 1'b0);
    @(negedge clk);
    checkOutput("run pviRise", bus.proc_valid_in, 1);
    hc = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.proc_valid_in) break;
      hc++;
      if (hc == 100) bus.proc_valid_out = 1'b1;
      @(negedge clk);
      bus.proc_valid_out = 1'b0;
    end
    checkOutput("run pviSpan", hc, 100);
    checkOutput("run err", bus.err, 0);
    checkOutput("run inReady", bus.in_ready, 1);

    // Dump with backpressure
    sendWord(16'hC025, 1'b0);
    sendWord(16'h0004, 1'b0);
    @(negedge clk);
    checkOutput("dump rdAddr", bus.dmem_addr, 37);
    checkOutput("dump validT1", bus.out_valid, 0);
    @(negedge clk);
    checkOutput("dump validT2", bus.out_valid, 0);
    @(negedge clk);
    checkOutput("dump validT3", bus.out_valid, 1);
    expW = '0;
    expW[0] = 16'h0040; expW[1] = 16'h0050; expW[2] = 16'h0055; expW[3] = 16'h0066;
    nW = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
    expW[4] = expSum;
    nW = 5;
`endif
    collectDump(expW, nW, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("dump backToCmd", bus.in_ready, 1);

    // Timeout on the short-watchdog instance
    sendWord(16'h8000, 1'b1);
    sendWord(16'h0000, 1'b1);
    hc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busTo.proc_valid_in) break;
      hc++;
    end
    checkOutput("timeout span", hc, 16);
    checkOutput("timeout err", busTo.err, 1);
    @(negedge clk);
    checkOutput("timeout pvi", busTo.proc_valid_in, 0);
    checkOutput("timeout inReady", busTo.in_ready, 1);

    // Mid-load reset after 2 of 4 payload words
    sendWord(16'h4064, 1'b0);
    sendWord(16'h0004, 1'b0);
    sendWord(16'hAAAA, 1'b0);
    sendWord(16'h0001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("midReset");
    checkOutput("midReset partial0", dmem[100], 16'hAAAA);
    checkOutput("midReset partial1", dmem[101], 16'h0001);
    expSum = '0;
    rst = 1'b0;
    post = '{cmd: 16'h40C8, len: 16'd2,
             data: {16'h0000, 16'h0000, 16'h0101, 16'h1234}, isImem: 1'b0,
             addr: {8'd0, 8'd0, 8'd201, 8'd200}, nWr: 3'd2};
    applyStimulus(post, 3);

    // Single-word dump after reset; with the checksum build the sum trails it
    sendWord(16'hC0C8, 1'b0);
    sendWord(16'h0001, 1'b0);
    @(negedge clk);
    expW = '0;
    expW[0] = 16'h1234;
    nW = 1;
`ifdef PROG_LOADER_CHECKSUM_EN
    expW[1] = expSum;
    nW = 2;
`endif
    collectDump(expW, nW, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
